// File: rtl/tone_mixer_pkg.sv
// Shared types and helpers for the tone mixer: FSM state encoding and the
// mixer sum width derived from channel count and volume width.
package tone_mixer_pkg;

  typedef enum logic [1:0] {
    MUTED     = 2'd0,
    RAMP_UP   = 2'd1,
    ACTIVE    = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  // Width that holds the sum of nch unsigned volw-bit values without overflow.
  function automatic int calc_sumw(input int nch, input int volw);
    return volw + $clog2(nch);
  endfunction

endpackage

// File: rtl/tone_mixer_sync.sv
// Two-flop synchroniser for one asynchronous bit; latency 2 clk, no backpressure.
// Asynchronous active-high reset clears both stages to 0.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/tone_mixer.sv
// Mixes NCH synchronised square-wave tones by volume, applies a click-free mute ramp and
// drives one PWM pin; level/att/state change only at PWM period boundaries, no backpressure.
module tone_mixer
  import tone_mixer_pkg::*;
#(
  parameter int NCH          = 4,
  parameter int VOLW         = 4,
  parameter int PWMW         = 8,
  parameter int RAMP_PERIODS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NCH-1:0]      tone,
  input  logic [NCH-1:0]      ch_en,
  input  logic [NCH*VOLW-1:0] vol,
  input  logic                master_en,
  output logic                pwm_out,
  output logic [PWMW-1:0]     level,
  output logic                period_strobe,
  output logic                muted
);

  localparam int SUMW = calc_sumw(NCH, VOLW);
  localparam int ATTW = $clog2(SUMW + 1);
  localparam int RCW  = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
  localparam logic [ATTW-1:0] ATT_MAX = ATTW'(SUMW);
  localparam logic [RCW-1:0]  RC_LAST = RCW'(RAMP_PERIODS - 1);

  logic [NCH-1:0]  ts;
  logic [SUMW-1:0] sum;
  logic [SUMW-1:0] atten;
  logic [PWMW-1:0] duty;
  logic [PWMW-1:0] cnt;
  logic            wrap;
  logic [ATTW-1:0] att, att_nxt;
  logic [RCW-1:0]  rcnt, rcnt_nxt;
  logic            step_due;
  state_t          state, state_nxt;

  for (genvar g = 0; g < NCH; g++) begin : g_sync
    sync2 u_sync (.clk(clk), .rst(rst), .d(tone[g]), .q(ts[g]));
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ts[i] && ch_en[i]) sum = sum + SUMW'(vol[i*VOLW +: VOLW]);
    end
  end

  assign atten = sum >> att;
  assign duty  = PWMW'(atten) << (PWMW - SUMW);
  assign wrap  = (cnt == '1);
  assign step_due = (rcnt == RC_LAST);

  // Reversal has priority over a pending step; ramp counter restarts on any state change.
  always_comb begin
    state_nxt = state;
    att_nxt   = att;
    rcnt_nxt  = rcnt;
    if (wrap) begin
      case (state)
        MUTED: begin
          if (master_en) state_nxt = RAMP_UP;
        end
        RAMP_UP: begin
          if (!master_en) begin
            state_nxt = (att == ATT_MAX) ? MUTED : RAMP_DOWN;
          end else if (step_due) begin
            att_nxt  = att - ATTW'(1);
            rcnt_nxt = '0;
            if (att == ATTW'(1)) state_nxt = ACTIVE;
          end else begin
            rcnt_nxt = rcnt + RCW'(1);
          end
        end
        ACTIVE: begin
          if (!master_en) state_nxt = RAMP_DOWN;
        end
        RAMP_DOWN: begin
          if (master_en) begin
            state_nxt = (att == '0) ? ACTIVE : RAMP_UP;
          end else if (step_due) begin
            att_nxt  = att + ATTW'(1);
            rcnt_nxt = '0;
            if (att == ATT_MAX - ATTW'(1)) state_nxt = MUTED;
          end else begin
            rcnt_nxt = rcnt + RCW'(1);
          end
        end
        default: state_nxt = MUTED;
      endcase
      if (state_nxt != state) rcnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      level   <= '0;
      pwm_out <= 1'b0;
      att     <= ATT_MAX;
      rcnt    <= '0;
      state   <= MUTED;
    end else begin
      cnt     <= cnt + PWMW'(1);
      pwm_out <= (cnt < level);
      att     <= att_nxt;
      rcnt    <= rcnt_nxt;
      state   <= state_nxt;
      if (wrap) level <= duty;
    end
  end

  // Gated by rst so the strobe reads 0 while reset holds cnt at 0.
  assign period_strobe = (cnt == '0) && !rst;
  assign muted         = (state == MUTED);

endmodule

// File: tb/tb_tone_mixer.sv
// Self-checking bench for tone_mixer: randomized stimulus against a boundary-level
// behavioural model (attenuation walks toward the requested target one step per period).
module tb_tone_mixer;

  localparam int RP = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  tone = '0;
  logic [3:0]  ch_en = '0;
  logic [15:0] vol = '0;
  logic        master_en = 1'b0;
  logic        pwm_out;
  logic [7:0]  level;
  logic        period_strobe;
  logic        muted;

  int n_cmp = 0;
  int n_err = 0;

  tone_mixer #(.NCH(4), .VOLW(4), .PWMW(8), .RAMP_PERIODS(RP)) dut (
    .clk(clk), .rst(rst), .tone(tone), .ch_en(ch_en), .vol(vol),
    .master_en(master_en), .pwm_out(pwm_out), .level(level),
    .period_strobe(period_strobe), .muted(muted)
  );

  always #5 clk = ~clk;

  // Bench's own view of the PWM counter.
  logic [7:0] bcnt;
  always @(posedge clk or posedge rst) begin
    if (rst) bcnt <= '0;
    else     bcnt <= bcnt + 8'd1;
  end

  // Reference model: evaluated once per period boundary.
  int         m_att, m_dir, m_pc, m_sum, m_tgt, m_want;
  logic [7:0] m_level;
  logic [3:0] ts1, ts2;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_att = 6; m_dir = 0; m_pc = 0; m_level = '0; ts1 = '0; ts2 = '0;
    end else begin
      if (bcnt == 8'd255) begin
        m_sum = 0;
        for (int i = 0; i < 4; i++)
          if (ts2[i] && ch_en[i]) m_sum += int'(vol[i*4 +: 4]);
        m_level = 8'((m_sum >> m_att) * 4);
        m_tgt  = master_en ? 0 : 6;
        m_want = master_en ? -1 : 1;
        if (m_att == m_tgt) begin
          m_dir = 0; m_pc = 0;
        end else if (m_dir != m_want) begin
          m_dir = m_want; m_pc = 0;
        end else begin
          m_pc++;
          if (m_pc == RP) begin m_att += m_want; m_pc = 0; end
        end
      end
      ts2 = ts1;
      ts1 = tone;
    end
  end

  function automatic logic model_muted();
    return (m_att == 6) && (m_dir != -1);
  endfunction

  task automatic wait_boundary();
    int lim = 0;
    do begin
      @(negedge clk);
      lim++;
    end while (bcnt != 8'd0 && lim < 300);
  endtask

  task automatic test_reset();
    rst = 1'b1; tone = '0; ch_en = '0; vol = '0; master_en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 1024; c++) begin
      @(negedge clk);
      n_cmp += 4;
      if (muted !== 1'b1) begin n_err++; $display("FAIL reset_muted cyc=%0d got=%b exp=1", c, muted); end
      if (level !== 8'd0) begin n_err++; $display("FAIL reset_level cyc=%0d got=%0d exp=0", c, level); end
      if (pwm_out !== 1'b0) begin n_err++; $display("FAIL reset_pwm cyc=%0d got=%b exp=0", c, pwm_out); end
      if (period_strobe !== (bcnt == 8'd0)) begin
        n_err++; $display("FAIL reset_strobe cyc=%0d got=%b exp=%b", c, period_strobe, bcnt == 8'd0);
      end
    end
  endtask

  task automatic test_ramp_up();
    logic [7:0] seq[$];
    logic [7:0] exp_seq[7];
    int hi;
    exp_seq = '{8'd0, 8'd4, 8'd12, 8'd28, 8'd60, 8'd120, 8'd240};
    wait_boundary();
    tone = 4'hF; vol = 16'hFFFF; ch_en = 4'hF; master_en = 1'b1;
    seq.push_back(level);
    for (int p = 0; p < 10; p++) begin
      wait_boundary();
      n_cmp++;
      if (level !== m_level) begin n_err++; $display("FAIL ramp_up_level p=%0d got=%0d exp=%0d", p, level, m_level); end
      if (level != seq[$]) seq.push_back(level);
    end
    n_cmp++;
    if (seq.size() != 7) begin
      n_err++; $display("FAIL ramp_up_seq_len got=%0d exp=7", seq.size());
    end else begin
      for (int k = 0; k < 7; k++) begin
        n_cmp++;
        if (seq[k] !== exp_seq[k]) begin n_err++; $display("FAIL ramp_up_seq k=%0d got=%0d exp=%0d", k, seq[k], exp_seq[k]); end
      end
    end
    n_cmp++;
    if (muted !== 1'b0) begin n_err++; $display("FAIL ramp_up_muted got=%b exp=0", muted); end
    hi = 0;
    @(negedge clk);
    for (int c = 0; c < 256; c++) begin
      hi += int'(pwm_out);
      @(negedge clk);
    end
    n_cmp++;
    if (hi != 240) begin n_err++; $display("FAIL active_duty got=%0d exp=240", hi); end
  endtask

  task automatic test_mix();
    wait_boundary();
    tone = 4'b0011; vol = 16'h0035; ch_en = 4'b1101;
    wait_boundary();
    n_cmp += 2;
    if (level !== 8'd20) begin n_err++; $display("FAIL mix_ch1_off got=%0d exp=20", level); end
    if (level !== m_level) begin n_err++; $display("FAIL mix_model_a got=%0d exp=%0d", level, m_level); end
    ch_en = 4'hF;
    repeat (128) @(negedge clk);
    n_cmp++;
    if (level !== 8'd20) begin n_err++; $display("FAIL mix_mid_period got=%0d exp=20", level); end
    wait_boundary();
    n_cmp += 2;
    if (level !== 8'd32) begin n_err++; $display("FAIL mix_ch1_on got=%0d exp=32", level); end
    if (level !== m_level) begin n_err++; $display("FAIL mix_model_b got=%0d exp=%0d", level, m_level); end
  endtask

  task automatic test_ramp_down();
    logic [7:0] exp_lv[6];
    int found;
    exp_lv = '{8'd60, 8'd60, 8'd28, 8'd12, 8'd4, 8'd0};
    master_en = 1'b0;
    for (int p = 0; p < 10; p++) wait_boundary();
    n_cmp++;
    if (muted !== 1'b1) begin n_err++; $display("FAIL down_premute got=%b exp=1", muted); end
    tone = 4'hF; vol = 16'hFFFF; ch_en = 4'hF; master_en = 1'b1;
    found = 0;
    for (int p = 0; p < 20 && found == 0; p++) begin
      wait_boundary();
      if (level == 8'd28) found = 1;
    end
    n_cmp++;
    if (found == 0) begin n_err++; $display("FAIL down_reach28 got=%0d exp=28", level); end
    master_en = 1'b0;
    for (int k = 0; k < 6; k++) begin
      wait_boundary();
      n_cmp += 2;
      if (level !== exp_lv[k]) begin n_err++; $display("FAIL down_seq k=%0d got=%0d exp=%0d", k, level, exp_lv[k]); end
      if (level !== m_level) begin n_err++; $display("FAIL down_model k=%0d got=%0d exp=%0d", k, level, m_level); end
    end
    n_cmp++;
    if (muted !== 1'b1) begin n_err++; $display("FAIL down_muted got=%b exp=1", muted); end
  endtask

  task automatic test_toggle();
    logic [7:0] lv;
    tone = 4'h0; vol = 16'h000F; ch_en = 4'h1; master_en = 1'b1;
    for (int p = 0; p < 10; p++) wait_boundary();
    for (int p = 0; p < 6; p++) begin
      wait_boundary();
      lv = level;
      n_cmp++;
      if (lv !== m_level) begin n_err++; $display("FAIL toggle_boundary p=%0d got=%0d exp=%0d", p, lv, m_level); end
      for (int c = 1; c < 256; c++) begin
        @(negedge clk);
        if ($urandom_range(15) == 0) tone[0] = ~tone[0];
        n_cmp++;
        if (level !== lv) begin n_err++; $display("FAIL toggle_hold p=%0d c=%0d got=%0d exp=%0d", p, c, level, lv); end
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] plev;
    int hi, have;
    have = 0; hi = 0; plev = '0;
    for (int c = 0; c < 8000; c++) begin
      @(negedge clk);
      n_cmp += 2;
      if (level !== m_level) begin n_err++; $display("FAIL rand_level c=%0d got=%0d exp=%0d", c, level, m_level); end
      if (muted !== model_muted()) begin n_err++; $display("FAIL rand_muted c=%0d got=%b exp=%b", c, muted, model_muted()); end
      if (bcnt == 8'd1) begin
        if (have != 0) begin
          n_cmp++;
          if (hi != int'(plev)) begin n_err++; $display("FAIL rand_duty c=%0d got=%0d exp=%0d", c, hi, plev); end
        end
        plev = m_level; hi = 0; have = 1;
      end
      hi += int'(pwm_out);
      if ($urandom_range(700) == 0) master_en = ~master_en;
      if ($urandom_range(300) == 0) vol = 16'($urandom);
      if ($urandom_range(300) == 0) ch_en = 4'($urandom);
      if ($urandom_range(40) == 0) tone = 4'($urandom);
    end
  endtask

  task automatic test_reset_mid();
    tone = 4'hF; vol = 16'hFFFF; ch_en = 4'hF; master_en = 1'b1;
    for (int p = 0; p < 10; p++) wait_boundary();
    while (bcnt != 8'd100) @(negedge clk);
    n_cmp++;
    if (pwm_out !== 1'b1) begin n_err++; $display("FAIL mid_pre_pwm got=%b exp=1", pwm_out); end
    #2 rst = 1'b1;
    #1;
    n_cmp += 4;
    if (pwm_out !== 1'b0) begin n_err++; $display("FAIL mid_rst_pwm got=%b exp=0", pwm_out); end
    if (level !== 8'd0) begin n_err++; $display("FAIL mid_rst_level got=%0d exp=0", level); end
    if (muted !== 1'b1) begin n_err++; $display("FAIL mid_rst_muted got=%b exp=1", muted); end
    if (period_strobe !== 1'b0) begin n_err++; $display("FAIL mid_rst_strobe got=%b exp=0", period_strobe); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (period_strobe !== 1'b1) begin n_err++; $display("FAIL mid_cnt_zero got=%b exp=1", period_strobe); end
    for (int p = 0; p < 10; p++) begin
      wait_boundary();
      n_cmp++;
      if (level !== m_level) begin n_err++; $display("FAIL mid_reramp p=%0d got=%0d exp=%0d", p, level, m_level); end
    end
    n_cmp++;
    if (level !== 8'd240) begin n_err++; $display("FAIL mid_final got=%0d exp=240", level); end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_mix();
    test_ramp_down();
    test_toggle();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
